// File: rtl/pattern_ram_pkg.sv
// -----------------------------------------------------------------------------
// pattern_ram_pkg
// Shared definitions for the pattern RAM arbiter slice: default RAM geometry,
// the clear-sequencer state type and the requester tag carried alongside reads
// so returning data can be routed back to whoever asked for it.
// -----------------------------------------------------------------------------
package pattern_ram_pkg;

  // Default geometry: 1024 words of 16 bits, two byte lanes.
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int BE_W       = 2;

  // Clear sequencer: IDLE lets normal traffic through, CLEAR owns the RAM.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Who a RAM read belongs to; NONE marks writes and empty slots.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    HOST = 2'd1,
    VID  = 2'd2
  } req_tag_t;

endpackage

// File: rtl/pattern_ram_clear_seq.sv
// -----------------------------------------------------------------------------
// pattern_ram_clear_seq
// Walks the whole pattern RAM writing zeros, one word per cycle, ascending.
// After clr_start the sequencer spends one cycle per address issuing a write
// (clr_issue), then one final cycle with nothing issued while the last write
// (address 2**ADDR_W-1) sits on the RAM bus; clr_done pulses in that cycle and
// the sequencer drops back to IDLE.
//
// Ports
//   clk, reset   single clock, asynchronous active-high reset
//   clr_start    pulse; ignored while a clear is already running
//   clr_active   sequencer owns the RAM this cycle (blocks host and video)
//   clr_issue    a clear write to clr_addr is issued this cycle
//   clr_addr     address of the clear write being issued
//   clr_done     one-cycle pulse while the final clear write is on the bus
// -----------------------------------------------------------------------------
module pattern_ram_clear_seq
  import pattern_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_start,
  output logic              clr_active,
  output logic              clr_issue,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_done
);

  clr_state_t state, state_nxt;

  // One bit wider than an address: the MSB sets once every address has been
  // issued, which marks the drain cycle.
  logic [ADDR_W:0] cnt, cnt_nxt;

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    clr_active = 1'b0;
    clr_issue  = 1'b0;
    clr_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        clr_active = 1'b1;
        if (cnt[ADDR_W]) begin
          // Drain cycle: last address is on the RAM bus right now.
          clr_done  = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          clr_issue = 1'b1;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

// File: rtl/pattern_ram_arbiter.sv
// -----------------------------------------------------------------------------
// pattern_ram_arbiter
// Shares one single-port pattern RAM between an Avalon host, a video scanout
// reader and a whole-RAM clear sequencer. At most one requester is granted per
// cycle (clear > video > host), except that a host denied STARVE_LIMIT times
// in a row takes the next slot ahead of video. The grant decision is
// combinational; the winning command is registered onto ram_* at the end of
// the grant cycle. RAM read data arrives one cycle after the address, so a
// two-stage tag pipeline steers it to host_readdata or vid_rdata two cycles
// after the grant.
//
// Ports
//   clk, reset                   single clock, asynchronous active-high reset
//   host_*                       Avalon-MM slave side (waitrequest, pipelined
//                                readdatavalid); read+write together = write
//   vid_req/vid_addr/vid_ready   video read request and combinational accept
//   vid_rvalid/vid_rdata         video read return
//   clr_start/clr_done           start a full zero-fill / completion pulse
//   ram_*                        registered command to the RAM, readdata back
// -----------------------------------------------------------------------------
module pattern_ram_arbiter
  import pattern_ram_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              host_chipselect,
  input  logic              host_read,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [BE_W-1:0]   host_byteenable,
  input  logic [DATA_W-1:0] host_writedata,
  output logic              host_waitrequest,
  output logic              host_readdatavalid,
  output logic [DATA_W-1:0] host_readdata,

  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ready,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,

  input  logic              clr_start,
  output logic              clr_done,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  input  logic [DATA_W-1:0] ram_readdata
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  logic              clr_active;
  logic              clr_issue;
  logic [ADDR_W-1:0] clr_addr;

  pattern_ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clr_start  (clr_start),
    .clr_active (clr_active),
    .clr_issue  (clr_issue),
    .clr_addr   (clr_addr),
    .clr_done   (clr_done)
  );

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic                host_pend;
  logic                host_is_write;
  logic                host_forced;
  logic                gnt_host;
  logic                gnt_vid;
  logic [STARVE_W-1:0] starve_cnt;

  assign host_pend     = host_chipselect & (host_read | host_write);
  assign host_is_write = host_write;
  assign host_forced   = host_pend && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    gnt_host = 1'b0;
    gnt_vid  = 1'b0;
    if (!clr_active) begin
      if (host_forced)    gnt_host = 1'b1;
      else if (vid_req)   gnt_vid  = 1'b1;
      else if (host_pend) gnt_host = 1'b1;
    end
  end

  assign host_waitrequest = host_pend & ~gnt_host;
  assign vid_ready        = gnt_vid;

  // Counts consecutive cycles the host waited; any cycle the host is served
  // or not asking restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (host_pend && !gnt_host) begin
      if (starve_cnt != STARVE_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM command
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_address    <= '0;
      ram_byteenable <= '0;
      ram_writedata  <= '0;
    end else begin
      ram_chipselect <= clr_issue | gnt_host | gnt_vid;
      ram_write      <= clr_issue | (gnt_host & host_is_write);
      if (clr_issue) begin
        ram_address    <= clr_addr;
        ram_byteenable <= '1;
        ram_writedata  <= '0;
      end else if (gnt_host) begin
        ram_address    <= host_address;
        ram_byteenable <= host_byteenable;
        ram_writedata  <= host_writedata;
      end else if (gnt_vid) begin
        ram_address    <= vid_addr;
        ram_byteenable <= '1;
        ram_writedata  <= '0;
      end else begin
        ram_address    <= '0;
        ram_byteenable <= '0;
        ram_writedata  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return tag pipeline: stage 1 lines up with the address on ram_*,
  // stage 2 with the data on ram_readdata.
  // ---------------------------------------------------------------------------
  req_tag_t tag_new, tag_d1, tag_d2;

  always_comb begin
    tag_new = NONE;
    if (gnt_host && !host_is_write) tag_new = HOST;
    else if (gnt_vid)               tag_new = VID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_d1 <= NONE;
      tag_d2 <= NONE;
    end else begin
      tag_d1 <= tag_new;
      tag_d2 <= tag_d1;
    end
  end

  // Data is gated so outputs read as zero whenever nothing is returning.
  assign host_readdatavalid = (tag_d2 == HOST);
  assign vid_rvalid         = (tag_d2 == VID);
  assign host_readdata      = host_readdatavalid ? ram_readdata : '0;
  assign vid_rdata          = vid_rvalid         ? ram_readdata : '0;

endmodule

// File: tb/tb_pattern_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pattern_ram_arbiter
// Drives the arbiter with directed and random traffic, models the pattern RAM
// behind it, and compares every cycle against a reference that tracks the
// arbitration rules, the starvation counter, the clear progress and the RAM
// contents with plain integers, an array and a queue of pending reads.
// -----------------------------------------------------------------------------
module tb_pattern_ram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int LIMIT  = 4;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_chipselect, host_read, host_write;
  logic [ADDR_W-1:0] host_address;
  logic [1:0]        host_byteenable;
  logic [DATA_W-1:0] host_writedata;
  logic              host_waitrequest, host_readdatavalid;
  logic [DATA_W-1:0] host_readdata;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ready, vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              clr_start, clr_done;
  logic [ADDR_W-1:0] ram_address;
  logic [1:0]        ram_byteenable;
  logic              ram_chipselect, ram_write;
  logic [DATA_W-1:0] ram_writedata, ram_readdata;

  pattern_ram_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .host_chipselect    (host_chipselect),
    .host_read          (host_read),
    .host_write         (host_write),
    .host_address       (host_address),
    .host_byteenable    (host_byteenable),
    .host_writedata     (host_writedata),
    .host_waitrequest   (host_waitrequest),
    .host_readdatavalid (host_readdatavalid),
    .host_readdata      (host_readdata),
    .vid_req            (vid_req),
    .vid_addr           (vid_addr),
    .vid_ready          (vid_ready),
    .vid_rvalid         (vid_rvalid),
    .vid_rdata          (vid_rdata),
    .clr_start          (clr_start),
    .clr_done           (clr_done),
    .ram_address        (ram_address),
    .ram_byteenable     (ram_byteenable),
    .ram_chipselect     (ram_chipselect),
    .ram_write          (ram_write),
    .ram_writedata      (ram_writedata),
    .ram_readdata       (ram_readdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM behind the arbiter: data one cycle after the address.
  logic [DATA_W-1:0] ram_arr [DEPTH];
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        if (ram_byteenable[0]) ram_arr[ram_address][7:0]  <= ram_writedata[7:0];
        if (ram_byteenable[1]) ram_arr[ram_address][15:8] <= ram_writedata[15:8];
      end else begin
        ram_readdata <= ram_arr[ram_address];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit                cs;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        be;
    logic [DATA_W-1:0] wd;
  } cmd_t;

  typedef struct {
    bit                to_host;
    int                due;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  rd_t               rq[$];
  cmd_t              exp_now;        // command expected on ram_* this cycle
  int                starve;         // consecutive host denials
  int                clr_k;          // -1 idle, else cycles into the clear
  int                cyc;
  int                last_g;         // model grant: 0 none, 1 host, 2 video
  logic              last_hwait, last_vready;
  logic [DATA_W-1:0] last_hrdata;
  int                done_pulses, clear_writes, overlaps;
  int                n_checks, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: sample at the falling edge, compare, advance the model,
  // then return just after the next rising edge so the caller can drive.
  task automatic tick();
    bit   hp, hw, exp_hv, exp_vv;
    int   g;
    rd_t  r;
    cmd_t nxt;
    @(negedge clk);
    hp = host_chipselect && (host_read || host_write);
    hw = host_write;

    // The write shown on ram_* now lands in the RAM at the coming edge.
    if (exp_now.cs && exp_now.wr) begin
      if (exp_now.be[0]) ref_mem[exp_now.addr][7:0]  = exp_now.wd[7:0];
      if (exp_now.be[1]) ref_mem[exp_now.addr][15:8] = exp_now.wd[15:8];
    end

    g = 0;
    if (clr_k < 0) begin
      if (hp && starve == LIMIT) g = 1;
      else if (vid_req)          g = 2;
      else if (hp)               g = 1;
    end

    check("vid_ready", vid_ready, g == 2);
    check("host_waitrequest", host_waitrequest, hp && g != 1);
    check("clr_done", clr_done, clr_k == DEPTH);
    check("ram_chipselect", ram_chipselect, exp_now.cs);
    check("ram_write", ram_write, exp_now.wr);
    if (exp_now.cs) check("ram_address", ram_address, exp_now.addr);
    if (exp_now.wr) begin
      check("ram_byteenable", ram_byteenable, exp_now.be);
      check("ram_writedata", ram_writedata, exp_now.wd);
    end

    exp_hv = rq.size() > 0 && rq[0].due == cyc && rq[0].to_host;
    exp_vv = rq.size() > 0 && rq[0].due == cyc && !rq[0].to_host;
    check("host_readdatavalid", host_readdatavalid, exp_hv);
    check("vid_rvalid", vid_rvalid, exp_vv);
    if (exp_hv) check("host_readdata", host_readdata, rq[0].data);
    if (exp_vv) check("vid_rdata", vid_rdata, rq[0].data);
    if (exp_hv || exp_vv) void'(rq.pop_front());

    if (host_readdatavalid && vid_rvalid) overlaps++;
    if (host_readdatavalid) last_hrdata = host_readdata;
    if (clr_done) done_pulses++;
    if (clr_k >= 1 && ram_chipselect && ram_write) clear_writes++;
    last_hwait  = host_waitrequest;
    last_vready = vid_ready;

    nxt = '{default: 0};
    if (clr_k >= 0 && clr_k < DEPTH) begin
      nxt = '{1'b1, 1'b1, 10'(clr_k), 2'b11, 16'h0000};
    end else if (g == 1) begin
      nxt = '{1'b1, hw, host_address, host_byteenable, host_writedata};
      if (!hw) begin
        r.to_host = 1'b1; r.due = cyc + 2; r.data = ref_mem[host_address];
        rq.push_back(r);
      end
    end else if (g == 2) begin
      nxt = '{1'b1, 1'b0, vid_addr, 2'b11, 16'h0000};
      r.to_host = 1'b0; r.due = cyc + 2; r.data = ref_mem[vid_addr];
      rq.push_back(r);
    end
    exp_now = nxt;

    if (hp && g != 1) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    else              starve = 0;

    if (clr_k == DEPTH)   clr_k = -1;
    else if (clr_k >= 0)  clr_k++;
    else if (clr_start)   clr_k = 0;

    last_g = g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_chipselect = 1'b0; host_read = 1'b0; host_write = 1'b0;
    host_address = '0; host_byteenable = '0; host_writedata = '0;
    vid_req = 1'b0; vid_addr = '0; clr_start = 1'b0;
  endtask

  // Asserted mid-cycle; everything in flight is forgotten.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    idle_inputs();
    #1;
    check("rst_ram_chipselect", ram_chipselect, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_host_readdatavalid", host_readdatavalid, 0);
    check("rst_host_readdata", host_readdata, 0);
    check("rst_vid_rvalid", vid_rvalid, 0);
    check("rst_vid_rdata", vid_rdata, 0);
    check("rst_vid_ready", vid_ready, 0);
    check("rst_host_waitrequest", host_waitrequest, 0);
    check("rst_clr_done", clr_done, 0);
    rq.delete();
    starve = 0; clr_k = -1; last_g = 0;
    exp_now = '{default: 0};
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // New requests appear with probability pct; an unaccepted one is held.
  task automatic rand_inputs(input int span, input int pct);
    if (!(host_chipselect && (host_read || host_write) && last_g != 1)) begin
      host_chipselect = ($urandom_range(0, 99) < pct);
      host_write      = ($urandom_range(0, 2) == 0);
      host_read       = !host_write || ($urandom_range(0, 3) == 0);
      host_address    = 10'($urandom_range(0, span - 1));
      host_byteenable = 2'($urandom_range(0, 3));
      host_writedata  = 16'($urandom);
    end
    if (!(vid_req && last_g != 2)) begin
      vid_req  = ($urandom_range(0, 99) < pct);
      vid_addr = 10'($urandom_range(0, span - 1));
    end
  endtask

  task automatic settle();
    repeat (12) begin
      rand_inputs(DEPTH, 0);
      tick();
    end
    idle_inputs();
  endtask

  task automatic host_access(input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [1:0] be, input logic [DATA_W-1:0] d);
    host_chipselect = 1'b1; host_write = wr; host_read = !wr;
    host_address = a; host_byteenable = be; host_writedata = d;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!last_hwait) break;
    end
    check("host_access_accepted", last_hwait, 0);
    host_chipselect = 1'b0; host_read = 1'b0; host_write = 1'b0;
  endtask

  task automatic run_clear();
    done_pulses = 0; clear_writes = 0;
    for (int i = 0; i < DEPTH + 40; i++) begin
      rand_inputs(64, 50);
      tick();
      if (done_pulses > 0) break;
    end
    check("clr_done_pulses", done_pulses, 1);
    check("clear_write_count", clear_writes, DEPTH);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] orig;
    int                denials;
    n_checks = 0; n_pass = 0; cyc = 0; overlaps = 0;
    for (int i = 0; i < DEPTH; i++) begin
      orig = 16'($urandom);
      ram_arr[i] = orig;
      ref_mem[i] = orig;
    end
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    apply_reset(2);
    tick();

    // Lone host read of 0x010.
    host_access(1'b0, 10'h010, 2'b11, 16'h0000);
    repeat (3) tick();

    // Video hogs every slot while a host read waits.
    vid_req = 1'b1; vid_addr = 10'($urandom);
    host_chipselect = 1'b1; host_read = 1'b1; host_address = 10'h0AA; host_byteenable = 2'b11;
    denials = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!last_hwait) break;
      denials++;
      vid_addr = 10'($urandom);
    end
    check("starve_denials", denials, LIMIT);
    check("vid_ready_when_forced", last_vready, 0);
    host_chipselect = 1'b0; host_read = 1'b0;
    tick();
    vid_req = 1'b0;
    repeat (3) tick();

    // Alternating video 0x3FF and host 0x001 reads, back to back.
    overlaps = 0;
    for (int i = 0; i < 10; i++) begin
      vid_req = (i % 2 == 0); vid_addr = 10'h3FF;
      host_chipselect = (i % 2 == 1); host_read = 1'b1; host_address = 10'h001;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    check("valid_overlap", overlaps, 0);

    // Low-byte-only write, then read it back.
    orig = ref_mem[10'h020];
    host_access(1'b1, 10'h020, 2'b01, 16'hBEEF);
    host_access(1'b0, 10'h020, 2'b11, 16'h0000);
    repeat (3) tick();
    check("byte_lane_merge", last_hrdata, {orig[15:8], 8'hEF});

    // Random mixed traffic.
    for (int i = 0; i < 300; i++) begin
      rand_inputs(32, 60);
      tick();
    end
    settle();

    // Clear started in the same cycle as a host read.
    host_chipselect = 1'b1; host_read = 1'b1; host_address = 10'h200; host_byteenable = 2'b11;
    clr_start = 1'b1;
    tick();
    check("host_granted_with_clr_start", last_hwait, 0);
    clr_start = 1'b0;
    host_chipselect = 1'b0; host_read = 1'b0;
    run_clear();
    settle();
    last_hrdata = 16'hFFFF;
    host_access(1'b0, 10'h200, 2'b11, 16'h0000);
    repeat (3) tick();
    check("read_after_clear", last_hrdata, 16'h0000);

    // Reset with reads in flight.
    for (int i = 0; i < 100; i++) begin
      rand_inputs(32, 60);
      tick();
    end
    settle();
    vid_req = 1'b1; vid_addr = 10'h155;
    tick();
    vid_req = 1'b0;
    apply_reset(1);
    overlaps = 0;
    repeat (4) tick();

    // Reset in the middle of a clear, then a full clear from address 0.
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    done_pulses = 0;
    for (int i = 0; i < 400 && clr_k != 'h100; i++) tick();
    check("clear_reached_0x100", clr_k, 'h100);
    apply_reset(1);
    repeat (4) tick();
    check("no_clr_done_after_abort", done_pulses, 0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    run_clear();
    settle();

    for (int i = 0; i < 200; i++) begin
      rand_inputs(DEPTH, 60);
      tick();
    end
    settle();
    repeat (3) tick();
    check("reads_drained", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_ram_arbiter.md
PATTERN_RAM_ARBITER -- requirements
Module: pattern_ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive host denials before host is forced a slot.
REQ-002 SHALL have parameter ADDR_W, default 10, and DATA_W, default 16 (1024x16 pattern RAM).
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- host_chipselect  in  1  Avalon host select.
- host_read  in  1  host read request.
- host_write  in  1  host write request.
- host_address  in  ADDR_W  host word address.
- host_byteenable  in  2  host byte lanes.
- host_writedata  in  DATA_W  host write data.
- host_waitrequest  out  1  host not accepted this cycle.
- host_readdatavalid  out  1  host read data valid.
- host_readdata  out  DATA_W  host read data.
- vid_req  in  1  video scanout read request.
- vid_addr  in  ADDR_W  video read address.
- vid_ready  out  1  video request accepted this cycle.
- vid_rvalid  out  1  video read data valid.
- vid_rdata  out  DATA_W  video read data.
- clr_start  in  1  pulse: zero entire RAM.
- clr_done  out  1  one-cycle pulse, clear finished.
- ram_address  out  ADDR_W  to RAM.
- ram_byteenable  out  2  to RAM.
- ram_chipselect  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_writedata  out  DATA_W  to RAM.
- ram_readdata  in  DATA_W  from RAM, valid one cycle after ram_address is presented.

Function
REQ-004 SHALL grant at most one requester per cycle; priority CLEAR > video > host, except REQ-006.
REQ-005 SHALL treat host as pending when host_chipselect & (host_read | host_write); if both read and write are set, the access is a write.
REQ-006 SHALL grant host, and drive vid_ready=0, when host is pending and starve_cnt == STARVE_LIMIT.
REQ-007 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle host is pending and not granted; it SHALL clear on host grant or when host is not pending.
REQ-008 host_waitrequest SHALL be combinational: 0 in the grant cycle, 1 when host is pending but not granted, 0 when host is not pending.
REQ-009 vid_ready SHALL be combinational; an unaccepted vid_req SHALL be held stable by the source.
REQ-010 The granted command SHALL be registered onto ram_* at the end of the grant cycle t; ram_chipselect=0 and ram_write=0 in cycles with no grant.
REQ-011 Read data SHALL return in cycle t+2 with exactly one of host_readdatavalid / vid_rvalid high, routed by a 2-stage requester-tag pipeline; back-to-back reads SHALL sustain one read per cycle.
REQ-012 A host write SHALL reach ram_* in cycle t+1 with ram_write=1 and SHALL NOT produce host_readdatavalid.
REQ-013 Clear FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on clr_start; clr_start SHALL be ignored while in CLEAR.
REQ-014 clr_start SHALL take effect the following cycle; requests in the clr_start cycle SHALL be arbitrated normally, and in-flight reads SHALL complete.
REQ-015 In CLEAR, the FSM SHALL issue one write per cycle of 0x0000 with byteenable 2'b11 to addresses 0..1023 ascending; host_waitrequest=1 (if pending) and vid_ready=0.
REQ-016 In the cycle address 1023 is on ram_*, clr_done SHALL pulse 1 and the FSM SHALL return to IDLE; normal grants resume in the next cycle.

Reset
REQ-017 On reset, all outputs SHALL be 0 (host_waitrequest follows REQ-008 combinationally), starve_cnt=0, tag-pipeline valids=0, FSM=IDLE, and the clear address=0.
REQ-018 Reset mid-operation SHALL discard in-flight reads (no valid pulses) and abort a clear without clr_done.

Structure
REQ-019 Package pattern_ram_pkg SHALL hold ADDR_W/DATA_W defaults, the clear-FSM state type, and the requester-tag type (NONE, HOST, VID).
REQ-020 The clear address counter and FSM SHALL be sub-module pattern_ram_clear_seq; arbitration and the tag pipeline SHALL remain in the top module.

Verification
REQ-021 Host read at 0x010 alone -> waitrequest=0 in cycle t; ram_address=0x010 in t+1; host_readdatavalid=1 with the RAM word in t+2.
REQ-022 Continuous vid_req plus host read pending, STARVE_LIMIT=4 -> host denied 4 cycles, granted in the 5th with vid_ready=0 that cycle.
REQ-023 Alternating video reads 0x3FF and host reads 0x001 back-to-back -> valids never overlap; each rdata matches the word at its own address.
REQ-024 Host write 0xBEEF to 0x020 with byteenable 2'b01, then read -> low byte 0xEF, high byte unchanged.
REQ-025 clr_start during a host read -> read completes; 1024 writes of 0x0000; clr_done on the address-1023 cycle; a subsequent read of 0x200 returns 0x0000.
REQ-026 reset asserted at clear address 0x100 -> no clr_done, no valid pulses, FSM IDLE; the next clr_start restarts at address 0.
